// File: rtl/alu_pkg.sv
// Shared ALU operation codes, MIPS opcode/funct constants, operand-select
// encodings and the immediate-extension helper used by the ALU issue stage.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD  = 5'b00000,
    ALU_OR   = 5'b00001,
    ALU_AND  = 5'b00010,
    ALU_SUB  = 5'b00110,
    ALU_SLT  = 5'b00111,
    ALU_SGT  = 5'b01000,
    ALU_NOR  = 5'b01100,
    ALU_XOR  = 5'b01101,
    ALU_SRL  = 5'b10000,
    ALU_SRA  = 5'b11000,
    ALU_SLL  = 5'b11001,
    ALU_ANDN = 5'b11010
  } alu_op_e;

  // Source of ALU operand 1
  typedef enum logic [1:0] {
    IN1_ZERO,
    IN1_RS,
    IN1_SHAMT,
    IN1_LUI
  } in1_sel_e;

  // Source of ALU operand 2
  typedef enum logic [1:0] {
    IN2_ZERO,
    IN2_RT,
    IN2_IMM
  } in2_sel_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // lui is executed as imm << 16
  localparam logic [31:0] LUI_SHIFT = 32'd16;

  function automatic logic [31:0] ext16(input logic [15:0] imm, input logic sext);
    return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
  endfunction

endpackage

// File: rtl/alu_issue_stage_decode.sv
// Combinational decode of a MIPS instruction into ALU operation, sign flag,
// operand sources, extended immediate and an illegal-instruction flag.
import alu_pkg::*;

module alu_decode (
  input  logic [31:0] instr,
  output alu_op_e     conf,
  output logic        sign,
  output in1_sel_e    in1_sel,
  output in2_sel_e    in2_sel,
  output logic [31:0] imm_ext,
  output logic        illegal
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       sext;
  logic       unused_idx;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  // Register indices are resolved by the forwarding logic in the top level
  assign unused_idx = ^instr[25:16];

  assign imm_ext = ext16(instr[15:0], sext);

  // Opcode/funct decode; anything unrecognised becomes ADD 0,0 flagged illegal
  always_comb begin
    conf    = ALU_ADD;
    sign    = 1'b0;
    in1_sel = IN1_ZERO;
    in2_sel = IN2_ZERO;
    sext    = 1'b0;
    illegal = 1'b0;
    if (opcode == OP_RTYPE) begin
      in1_sel = IN1_RS;
      in2_sel = IN2_RT;
      case (funct)
        FN_ADD, FN_ADDU: begin conf = ALU_ADD; sign = 1'b1; end
        FN_SUB, FN_SUBU: begin conf = ALU_SUB; sign = 1'b1; end
        FN_AND:  conf = ALU_AND;
        FN_OR:   conf = ALU_OR;
        FN_XOR:  conf = ALU_XOR;
        FN_NOR:  conf = ALU_NOR;
        FN_SLT:  begin conf = ALU_SLT; sign = 1'b1; end
        FN_SLTU: conf = ALU_SLT;
        FN_SLL:  begin conf = ALU_SLL; in1_sel = IN1_SHAMT; end
        FN_SRL:  begin conf = ALU_SRL; in1_sel = IN1_SHAMT; end
        FN_SRA:  begin conf = ALU_SRA; in1_sel = IN1_SHAMT; end
        FN_SLLV: conf = ALU_SLL;
        FN_SRLV: conf = ALU_SRL;
        FN_SRAV: conf = ALU_SRA;
        default: begin
          in1_sel = IN1_ZERO;
          in2_sel = IN2_ZERO;
          illegal = 1'b1;
        end
      endcase
    end else begin
      in1_sel = IN1_RS;
      in2_sel = IN2_IMM;
      case (opcode)
        OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
          conf = ALU_ADD; sign = 1'b1; sext = 1'b1;
        end
        OP_SLTI:  begin conf = ALU_SLT; sign = 1'b1; sext = 1'b1; end
        OP_SLTIU: begin conf = ALU_SLT; sext = 1'b1; end
        OP_ANDI:  conf = ALU_AND;
        OP_ORI:   conf = ALU_OR;
        OP_XORI:  conf = ALU_XOR;
        OP_LUI:   begin conf = ALU_SLL; in1_sel = IN1_LUI; end
        OP_BEQ, OP_BNE: begin
          conf = ALU_SUB; sign = 1'b1; in2_sel = IN2_RT;
        end
        default: begin
          in1_sel = IN1_ZERO;
          in2_sel = IN2_ZERO;
          illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the EX ALU: decode, operand select/forwarding and a
// one-entry valid/ready output register.
// Optional feature macro: ALU_ISSUE_FWD_EN enables EX/MEM operand forwarding.
import alu_pkg::*;

module alu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        fwd_ex_valid,
  input  logic        fwd_mem_valid,
  input  logic [4:0]  fwd_ex_rd,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_ex_data,
  input  logic [31:0] fwd_mem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  alu_conf,
  output logic        alu_sign,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        illegal
);

  alu_op_e     dec_conf;
  logic        dec_sign;
  in1_sel_e    dec_in1_sel;
  in2_sel_e    dec_in2_sel;
  logic [31:0] dec_imm;
  logic        dec_illegal;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        accept;

  alu_decode u_decode (
    .instr   (instr),
    .conf    (dec_conf),
    .sign    (dec_sign),
    .in1_sel (dec_in1_sel),
    .in2_sel (dec_in2_sel),
    .imm_ext (dec_imm),
    .illegal (dec_illegal)
  );

`ifdef ALU_ISSUE_FWD_EN
  function automatic logic [31:0] fwd_pick(
    input logic [4:0]  idx,
    input logic [31:0] rf,
    input logic        ex_v,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_d,
    input logic        mem_v,
    input logic [4:0]  mem_rd,
    input logic [31:0] mem_d
  );
    if (idx != 5'd0 && ex_v && ex_rd == idx)
      return ex_d;
    if (idx != 5'd0 && mem_v && mem_rd == idx)
      return mem_d;
    return rf;
  endfunction

  // Replace register-file values with the youngest in-flight result
  always_comb begin
    rs_val = fwd_pick(instr[25:21], rs_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                      fwd_mem_valid, fwd_mem_rd, fwd_mem_data);
    rt_val = fwd_pick(instr[20:16], rt_data, fwd_ex_valid, fwd_ex_rd, fwd_ex_data,
                      fwd_mem_valid, fwd_mem_rd, fwd_mem_data);
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^{fwd_ex_valid, fwd_mem_valid, fwd_ex_rd, fwd_mem_rd,
                        fwd_ex_data, fwd_mem_data};

  // Register-file values pass straight through
  always_comb begin
    rs_val = rs_data;
    rt_val = rt_data;
  end
`endif

  // Operand source muxes driven by the decoder
  always_comb begin
    op1 = '0;
    op2 = '0;
    case (dec_in1_sel)
      IN1_RS:    op1 = rs_val;
      IN1_SHAMT: op1 = {27'b0, instr[10:6]};
      IN1_LUI:   op1 = LUI_SHIFT;
      default:   op1 = '0;
    endcase
    case (dec_in2_sel)
      IN2_RT:  op2 = rt_val;
      IN2_IMM: op2 = dec_imm;
      default: op2 = '0;
    endcase
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output register: reset beats flush beats accept beats drain
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      alu_conf  <= '0;
      alu_sign  <= 1'b0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
      illegal   <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      alu_conf  <= dec_conf;
      alu_sign  <= dec_sign;
      alu_in1   <= op1;
      alu_in2   <= op2;
      illegal   <= dec_illegal;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

ID/EX pipeline stage that drives the EX-stage ALU. It decodes a MIPS instruction's opcode and funct into the ALU's 5-bit operation code and sign flag, and selects and extends the two operands. Operands are optionally forwarded from later stages. All of this is registered behind a valid/ready handshake. It sits between the register-file read in ID and the combinational ALU in EX, and is the sole producer of the ALU's control and data inputs.

## Interface
- No parameters; widths fixed at 32-bit datapath, 5-bit register index.
- clk  in  1  pipeline clock, all state on rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  synchronous kill of the held entry (branch/exception)
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage can accept this cycle
- instr  in  32  raw instruction word
- rs_data, rt_data  in  32 each  register-file read values
- fwd_ex_valid, fwd_mem_valid  in  1 each  forwarding source writes a register
- fwd_ex_rd, fwd_mem_rd  in  5 each  forwarding destination index
- fwd_ex_data, fwd_mem_data  in  32 each  forwarding values
- out_valid  out  1  ALU inputs are valid
- out_ready  in  1  EX consumes this cycle
- alu_conf  out  5  ALU operation code
- alu_sign  out  1  1 = signed compare
- alu_in1, alu_in2  out  32 each  ALU operands
- illegal  out  1  held entry has an undecodable opcode or funct

## Operation
- ALU codes: ADD 00000, OR 00001, AND 00010, SUB 00110, SLT 00111, SGT 01000, NOR 01100, XOR 01101, SRL 10000, SRA 11000, SLL 11001, ANDN 11010.
- R-type (opcode 0), default in1=rs, in2=rt, by funct:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x26 XOR; 0x27 NOR.
  - 0x2A SLT with sign=1; 0x2B SLT with sign=0.
  - 0x00/0x02/0x03 SLL/SRL/SRA with in1={27'b0,shamt}.
  - 0x04/0x06/0x07 SLL/SRL/SRA (variable) with in1=rs.
- I-type, in1=rs, in2 as follows:
  - 0x08/0x09 ADD with sign-extended imm.
  - 0x0A SLT with sign-extended imm, sign=1.
  - 0x0B SLT with sign-extended imm, sign=0.
  - 0x0C AND, 0x0D OR, 0x0E XOR, all with zero-extended imm.
  - 0x0F (lui) SLL with in1=16, in2=zero-extended imm.
  - 0x23/0x2B (lw/sw) ADD with sign-extended imm.
  - 0x04/0x05 (beq/bne) SUB with in2=rt.
- alu_sign=1 for add/sub/signed forms; 0 otherwise.
- Any other opcode or funct: alu_conf=ADD, operands 0, illegal=1.
- Accept condition: in_ready = !out_valid || out_ready, independent of flush.
- Capture: on in_valid && in_ready, decoded outputs load and out_valid←1.
- Drain: on out_valid && out_ready with no accept, out_valid←0. Data outputs hold their last value.

## Timing
- Latency: 1 cycle from accepted input to out_valid.
- Back-to-back accepts sustain 1 instruction/cycle while out_ready=1.
- Stall: out_valid && !out_ready holds all outputs stable, and in_ready=0.
- Flush has priority over accept: out_valid←0 and illegal←0. Any instruction offered that cycle is dropped.
- Reset (overrides flush and accept) sets every output register, out_valid and illegal to 0 on the next edge. in_ready=1 after reset.
- Reset asserted mid-stall discards the held entry.

## Configuration
- ALU_ISSUE_FWD_EN defined:
  - rs/rt are replaced by fwd_ex_data when fwd_ex_valid and fwd_ex_rd matches and is nonzero.
  - Otherwise they are replaced by fwd_mem_data under the same rule. EX has priority over MEM.
  - Register index 0 is never forwarded.
- Undefined: rs_data/rt_data are used unmodified, and the forwarding ports are ignored.

## Structure
- Package alu_pkg: the twelve ALU code constants, opcode and funct constants, and a sign/zero-extend function.
- Sub-module alu_decode is purely combinational: instr → conf, sign, operand-select, imm-extend and illegal.
- The top level holds the forwarding muxes, the output register and the handshake.

## Test plan
- add: instr 0x012A4020 (add $t0,$t1,$t2), rs=5, rt=7 → next cycle out_valid=1, conf=00000, sign=1, in1=5, in2=7.
- slti: slti with imm 0xFFFF → in2=0xFFFFFFFF, conf=00111, sign=1. sltiu with the same imm → sign=0. andi with the same imm → in2=0x0000FFFF.
- sll: sll shamt=4, rt=0x1 → in1=4, in2=1, conf=11001. lui imm=0x1234 → in1=16, in2=0x1234.
- Stall: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and outputs frozen. Release → queued instruction appears on the following cycle.
- Flush/reset:
  - flush together with an accept → out_valid=0 next cycle and the instruction is lost.
  - reset mid-stall → all outputs 0.
  - opcode 0x3F → illegal=1.
- Forwarding (ALU_ISSUE_FWD_EN):
  - rs index 9 with ex_rd=9, ex data 0xAA and mem_rd=9, mem data 0xBB → in1=0xAA.
  - rd=0 on both sources → rs_data used.
